vga_scan_timer: RTL



---
 rtl/vga_timing_pkg.sv | 37 +++
 rtl/vga_axis_counter.sv | 36 +++
 rtl/vga_scan_timer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : Default 640x480@60 raster constants, sync polarity and the
//               colour type shared by the VGA scan timer files.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    localparam int c_H_VISIBLE = 640;
    localparam int c_H_FRONT   = 16;
    localparam int c_H_SYNC    = 96;
    localparam int c_H_BACK    = 48;
    localparam int c_H_TOTAL   = c_H_VISIBLE + c_H_FRONT + c_H_SYNC + c_H_BACK;

    localparam int c_V_VISIBLE = 480;
    localparam int c_V_FRONT   = 10;
    localparam int c_V_SYNC    = 2;
    localparam int c_V_BACK    = 33;
    localparam int c_V_TOTAL   = c_V_VISIBLE + c_V_FRONT + c_V_SYNC + c_V_BACK;

    localparam logic c_SYNC_ACTIVE = 1'b0;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    function automatic logic in_range(input logic [9:0] val,
                                      input logic [9:0] lo,
                                      input logic [9:0] hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
// Module      : vga_axis_counter
// Description : Enabled modulo-TOTAL raster counter with terminal-count flag.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int TOTAL = c_H_TOTAL
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       en,
    output logic [9:0] cnt,
    output logic       wrap
);

    localparam logic [9:0] c_LAST = 10'(TOTAL - 1);

    logic [9:0] r_cnt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= (r_cnt == c_LAST) ? 10'd0 : r_cnt + 10'd1;
        end
    end

    assign cnt  = r_cnt;
    // Terminal count, independent of en so the caller can qualify it.
    assign wrap = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/vga_scan_timer.sv
`default_nettype none
// ============================================================================
// Module      : vga_scan_timer
// Description : VGA raster timing, pixel-aligned sync/colour output register
//               and one-cycle vertical-blank pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_scan_timer
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = c_H_VISIBLE,
    parameter int H_FRONT   = c_H_FRONT,
    parameter int H_SYNC    = c_H_SYNC,
    parameter int H_BACK    = c_H_BACK,
    parameter int V_VISIBLE = c_V_VISIBLE,
    parameter int V_FRONT   = c_V_FRONT,
    parameter int V_SYNC    = c_V_SYNC,
    parameter int V_BACK    = c_V_BACK,
    parameter int CLK_DIV   = 2
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [7:0] Red,
    input  logic [7:0] Green,
    input  logic [7:0] Blue,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       vblank_start
);

    localparam int         c_HTOT      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int         c_VTOT      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [9:0] c_HS_FIRST  = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] c_HS_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] c_VS_FIRST  = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] c_VS_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [9:0] c_H_VIS     = 10'(H_VISIBLE);
    localparam logic [9:0] c_V_VIS     = 10'(V_VISIBLE);
    localparam logic [9:0] c_V_VB_LAST = 10'(V_VISIBLE - 1);
    localparam logic [1:0] c_DIV_LAST  = 2'(CLK_DIV - 1);

    logic [1:0] r_div_cnt;
    logic [1:0] w_div_next;
    logic       w_pix_tick;
    logic [9:0] w_h_cnt;
    logic [9:0] w_v_cnt;
    logic       w_h_wrap;
    logic       w_v_en;
    logic       w_hs_n;
    logic       w_vs_n;
    logic       w_vis;
    rgb_t       w_rgb_next;
    rgb_t       r_rgb;
    logic       r_hs;
    logic       r_vs;
    logic       r_blank_n;
    logic       r_vblank_start;

    assign w_pix_tick = (r_div_cnt == c_DIV_LAST);
    assign w_div_next = w_pix_tick ? 2'd0 : r_div_cnt + 2'd1;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_div_cnt <= 2'd0;
        end else begin
            r_div_cnt <= w_div_next;
        end
    end

    assign w_v_en = w_pix_tick & w_h_wrap;

    vga_axis_counter #(
        .TOTAL   (c_HTOT)
    ) u_h_cnt (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .en      (w_pix_tick),
        .cnt     (w_h_cnt),
        .wrap    (w_h_wrap)
    );

    vga_axis_counter #(
        .TOTAL   (c_VTOT)
    ) u_v_cnt (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .en      (w_v_en),
        .cnt     (w_v_cnt),
        .wrap    ()
    );

    // Decode describes the pixel being presented now; it reaches the pins
    // one tick later together with the mapper colour for the same pixel.
    assign w_hs_n = in_range(w_h_cnt, c_HS_FIRST, c_HS_LAST) ? c_SYNC_ACTIVE : ~c_SYNC_ACTIVE;
    assign w_vs_n = in_range(w_v_cnt, c_VS_FIRST, c_VS_LAST) ? c_SYNC_ACTIVE : ~c_SYNC_ACTIVE;
    assign w_vis  = (w_h_cnt < c_H_VIS) && (w_v_cnt < c_V_VIS);

    always_comb begin
        w_rgb_next = '0;
        if (w_vis) begin
            w_rgb_next.r = Red;
            w_rgb_next.g = Green;
            w_rgb_next.b = Blue;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_hs      <= ~c_SYNC_ACTIVE;
            r_vs      <= ~c_SYNC_ACTIVE;
            r_blank_n <= 1'b0;
            r_rgb     <= '0;
        end else if (w_pix_tick) begin
            r_hs      <= w_hs_n;
            r_vs      <= w_vs_n;
            r_blank_n <= w_vis;
            r_rgb     <= w_rgb_next;
        end
    end

    // Registered on every Clk so the pulse is exactly one Clk wide and
    // coincides with the counters showing (0, V_VISIBLE).
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_vblank_start <= 1'b0;
        end else begin
            r_vblank_start <= w_v_en && (w_v_cnt == c_V_VB_LAST);
        end
    end

    generate
        if (CLK_DIV >= 2) begin : g_vga_clk_div
            localparam logic [1:0] c_DIV_HALF = 2'(CLK_DIV / 2);
            logic r_vga_clk;

            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n) begin
                    r_vga_clk <= 1'b0;
                end else begin
                    r_vga_clk <= (w_div_next >= c_DIV_HALF);
                end
            end

            assign VGA_CLK = r_vga_clk;
        end else begin : g_vga_clk_inv
            assign VGA_CLK = ~Clk & Reset_n;
        end
    endgenerate

    assign DrawX        = w_h_cnt;
    assign DrawY        = w_v_cnt;
    assign VGA_HS       = r_hs;
    assign VGA_VS       = r_vs;
    assign VGA_BLANK_N  = r_blank_n;
    assign VGA_SYNC_N   = 1'b0;
    assign VGA_R        = r_rgb.r;
    assign VGA_G        = r_rgb.g;
    assign VGA_B        = r_rgb.b;
    assign vblank_start = r_vblank_start;

endmodule
`default_nettype wire
